// File: rtl/ad_capture_ctrl.sv
// Acquisition sequencer: arms on start, decimates the AD sample stream, waits for an
// immediate/threshold/timeout trigger and writes len+1 samples into the capture RAM.
module ad_capture_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [7:0]        decim,
  input  logic [ADDR_W-1:0] len,
  input  logic [TMO_W-1:0]  tmo,
  input  logic [DATA_W-1:0] sample_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state, next_state;

  logic              trig_mode_l;
  logic [DATA_W-1:0] trig_level_l;
  logic [7:0]        decim_l;
  logic [ADDR_W-1:0] len_l;
  logic [TMO_W-1:0]  tmo_l;

  logic [7:0]        dcnt;
  logic [TMO_W-1:0]  tcnt;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic [ADDR_W-1:0] widx;

  logic              tick;
  logic              accept;
  logic              trig_hit;
  logic              tmo_hit;
  logic              trig_fire;
  logic              do_wr;
  logic [ADDR_W-1:0] wr_addr_n;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // abort has priority over everything, including a simultaneous start.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    trig_fire  = 1'b0;
    do_wr      = 1'b0;
    wr_addr_n  = widx;
    tick       = ((state == S_ARMED) || (state == S_CAPTURE)) && (dcnt == decim_l);
    trig_hit   = trig_mode_l ? (prev_valid && (prev < trig_level_l) && (sample_in >= trig_level_l))
                             : 1'b1;
    tmo_hit    = !trig_hit && (tmo_l != '0) && (tcnt == tmo_l - TMO_W'(1));
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            accept     = 1'b1;
            next_state = S_ARMED;
          end
        end
        S_ARMED: begin
          if (tick && (trig_hit || tmo_hit)) begin
            trig_fire  = 1'b1;
            do_wr      = 1'b1;
            wr_addr_n  = '0;
            next_state = (len_l != '0) ? S_CAPTURE : S_DONE;
          end
        end
        S_CAPTURE: begin
          if (tick) begin
            do_wr = 1'b1;
            if (widx == len_l) next_state = S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            accept     = 1'b1;
            next_state = S_ARMED;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      timed_out    <= 1'b0;
      trig_mode_l  <= 1'b0;
      trig_level_l <= '0;
      decim_l      <= '0;
      len_l        <= '0;
      tmo_l        <= '0;
      dcnt         <= '0;
      tcnt         <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      widx         <= '0;
    end else begin
      wr_en <= do_wr;
      if (do_wr) begin
        wr_addr <= wr_addr_n;
        wr_data <= sample_in;
      end
      if (accept) begin
        trig_mode_l  <= trig_mode;
        trig_level_l <= trig_level;
        decim_l      <= decim;
        len_l        <= len;
        tmo_l        <= tmo;
        dcnt         <= '0;
        tcnt         <= '0;
        prev         <= '0;
        prev_valid   <= 1'b0;
        widx         <= '0;
        timed_out    <= 1'b0;
      end else if (tick) begin
        dcnt <= '0;
        if (state == S_ARMED) begin
          prev       <= sample_in;
          prev_valid <= 1'b1;
          tcnt       <= tcnt + TMO_W'(1);
        end
        if (trig_fire) begin
          timed_out <= tmo_hit;
          widx      <= ADDR_W'(1);
        end else if (state == S_CAPTURE) begin
          widx <= widx + ADDR_W'(1);
        end
      end else if (busy) begin
        dcnt <= dcnt + 8'd1;
      end
    end
  end

  assign busy      = (state == S_ARMED) || (state == S_CAPTURE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Directed bench for ad_capture_ctrl: every RAM write is logged with its cycle number
// and compared against hand-computed expected writes; control outputs checked inline.
module tb_ad_capture_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int TMO_W  = 16;
  localparam int REC_W  = 32 + ADDR_W + DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst, start, abort, trig_mode;
  logic [DATA_W-1:0] trig_level, sample_in;
  logic [7:0]        decim;
  logic [ADDR_W-1:0] len;
  logic [TMO_W-1:0]  tmo;
  logic              wr_en, busy, done, timed_out;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        state_dbg;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] cyc      = 0;
  logic [31:0] c0;
  bit          ramp_on;
  int          got_rd   = 0;

  // record = {cycle, addr, data, done}
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];

  logic [DATA_W-1:0] thr_a[5];
  logic [DATA_W-1:0] thr_b[6];

  ad_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trig_mode(trig_mode),
    .trig_level(trig_level), .decim(decim), .len(len), .tmo(tmo), .sample_in(sample_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .timed_out(timed_out), .state_dbg(state_dbg)
  );

  // clock / reset
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({cyc, wr_addr, wr_data, done});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (ramp_on) sample_in = sample_in + 1'b1;
  endtask

  task automatic arm(input logic [7:0] d, input logic [ADDR_W-1:0] l, input logic m,
                     input logic [DATA_W-1:0] lvl, input logic [TMO_W-1:0] t);
    decim = d; len = l; trig_mode = m; trig_level = lvl; tmo = t;
    start = 1'b1;
  endtask

  task automatic expect_write(input logic [31:0] c, input int a, input int d, input bit dn);
    exp_q.push_back({c, ADDR_W'(a), DATA_W'(d), dn});
  endtask

  // scoreboard: compare writes logged since the last call against exp_q
  task automatic compare_writes(input string tag);
    int n_got;
    logic [REC_W-1:0] g, e;
    n_got = got_q.size() - got_rd;
    check({tag, "_count"}, 32'(n_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      g = got_q[got_rd + i];
      e = exp_q[i];
      check($sformatf("%s_w%0d_cyc", tag, i),  g[REC_W-1 -: 32], e[REC_W-1 -: 32]);
      check($sformatf("%s_w%0d_addr", tag, i), 32'(g[ADDR_W+DATA_W -: ADDR_W]),
            32'(e[ADDR_W+DATA_W -: ADDR_W]));
      check($sformatf("%s_w%0d_data", tag, i), 32'(g[DATA_W:1]), 32'(e[DATA_W:1]));
      check($sformatf("%s_w%0d_done", tag, i), 32'(g[0]), 32'(e[0]));
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    thr_a = '{16'd900, 16'd950, 16'd999, 16'd1000, 16'd1200};
    thr_b = '{16'd1500, 16'd1600, 16'd900, 16'd800, 16'd1100, 16'd1300};
    rst = 1'b1; start = 1'b0; abort = 1'b0; trig_mode = 1'b0; trig_level = '0;
    decim = '0; len = '0; tmo = '0; sample_in = '0; ramp_on = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timed_out", 32'(timed_out), 0);
    check("rst_state", 32'(state_dbg), 0);
    step();

    // immediate, no decimation, ramp
    sample_in = '0; ramp_on = 1'b1;
    arm(8'd0, 10'd3, 1'b0, 16'd0, 16'd0); c0 = cyc;
    step(); start = 1'b0;
    check("imm_busy_rise", 32'(busy), 1);
    repeat (4) step();
    check("imm_done", 32'(done), 1);
    check("imm_busy_fall", 32'(busy), 0);
    repeat (3) step();
    check("imm_addr_hold", 32'(wr_addr), 3);
    for (int i = 0; i < 4; i++) expect_write(c0 + 2 + i, i, 1 + i, i == 3);
    compare_writes("imm");

    // decimation by 3, re-armed from DONE
    sample_in = '0;
    arm(8'd2, 10'd1, 1'b0, 16'd0, 16'd0); c0 = cyc;
    step(); start = 1'b0;
    check("dec_done_cleared", 32'(done), 0);
    repeat (10) step();
    check("dec_done", 32'(done), 1);
    expect_write(c0 + 4, 0, 3, 0);
    expect_write(c0 + 7, 1, 6, 1);
    compare_writes("dec");

    // threshold rising crossing
    ramp_on = 1'b0; sample_in = '0;
    arm(8'd0, 10'd1, 1'b1, 16'd1000, 16'd0); c0 = cyc;
    step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin sample_in = thr_a[i]; step(); end
    repeat (2) step();
    check("thr_timed_out", 32'(timed_out), 0);
    expect_write(c0 + 5, 0, 1000, 0);
    expect_write(c0 + 6, 1, 1200, 1);
    compare_writes("thr");

    // stream starting above level must fall below and re-cross
    sample_in = '0;
    arm(8'd0, 10'd0, 1'b1, 16'd1000, 16'd0); c0 = cyc;
    step(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin sample_in = thr_b[i]; step(); end
    repeat (2) step();
    check("thr2_done", 32'(done), 1);
    expect_write(c0 + 6, 0, 1100, 1);
    compare_writes("thr2");

    // timeout forces trigger on 5th tick
    sample_in = '0; ramp_on = 1'b1;
    arm(8'd0, 10'd2, 1'b1, 16'hFFFF, 16'd5); c0 = cyc;
    step(); start = 1'b0;
    repeat (8) step();
    check("tmo_timed_out", 32'(timed_out), 1);
    check("tmo_done", 32'(done), 1);
    expect_write(c0 + 6, 0, 5, 0);
    expect_write(c0 + 7, 1, 6, 0);
    expect_write(c0 + 8, 2, 7, 1);
    compare_writes("tmo");

    // start+abort together from DONE: abort wins, start not accepted
    start = 1'b1; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0;
    check("sa_state", 32'(state_dbg), 0);
    check("sa_done", 32'(done), 0);
    check("sa_busy", 32'(busy), 0);
    check("sa_timed_out_kept", 32'(timed_out), 1);
    arm(8'd0, 10'd0, 1'b1, 16'hFFFF, 16'd0);
    step(); start = 1'b0;
    check("rearm_busy", 32'(busy), 1);
    check("rearm_timed_out_clr", 32'(timed_out), 0);
    abort = 1'b1;
    step(); abort = 1'b0;
    check("armed_abort_busy", 32'(busy), 0);
    check("armed_abort_state", 32'(state_dbg), 0);
    compare_writes("armed_abort");

    // abort mid-capture at addr 2, with an ignored start during CAPTURE
    sample_in = '0;
    arm(8'd0, 10'd7, 1'b0, 16'd0, 16'd0); c0 = cyc;
    step(); start = 1'b0;
    step();
    step();
    start = 1'b1; decim = 8'd5; len = 10'd0;
    step(); start = 1'b0;
    check("ab_addr2", 32'(wr_addr), 2);
    abort = 1'b1;
    step(); abort = 1'b0;
    check("ab_busy", 32'(busy), 0);
    check("ab_done", 32'(done), 0);
    check("ab_state", 32'(state_dbg), 0);
    check("ab_wr_en", 32'(wr_en), 0);
    repeat (10) step();
    for (int i = 0; i < 3; i++) expect_write(c0 + 2 + i, i, 1 + i, 0);
    compare_writes("ab");

    // reset mid-capture of a timeout-forced capture (tmo=1 fires on first tick)
    sample_in = '0;
    arm(8'd0, 10'd7, 1'b1, 16'hFFFF, 16'd1); c0 = cyc;
    step(); start = 1'b0;
    step();
    check("rc_timed_out", 32'(timed_out), 1);
    step();
    rst = 1'b1;
    step(); rst = 1'b0;
    check("rc_wr_en", 32'(wr_en), 0);
    check("rc_wr_addr", 32'(wr_addr), 0);
    check("rc_wr_data", 32'(wr_data), 0);
    check("rc_busy", 32'(busy), 0);
    check("rc_done", 32'(done), 0);
    check("rc_timed_out_clr", 32'(timed_out), 0);
    check("rc_state", 32'(state_dbg), 0);
    repeat (10) step();
    expect_write(c0 + 2, 0, 1, 0);
    expect_write(c0 + 3, 1, 2, 0);
    compare_writes("rc");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ad_capture_ctrl.md
Name: ad_capture_ctrl

Overview:
- Sequences one acquisition of the millivolt sample stream from the AD front end into a sample RAM.
- Control path: software/host arms the block; it decimates the stream, waits for an immediate or threshold trigger (with auto-trigger timeout), writes a block of samples, then flags done.
- Sits between the AD voltage-conversion output and the capture RAM read by the correlation engine.

Parameters:
- DATA_W, 16, width of sample_in / wr_data (mV sample, unsigned).
- ADDR_W, 10, capture RAM address width; max capture 2^ADDR_W samples.
- TMO_W, 16, width of the auto-trigger timeout counter.

Ports:
- clk  in  1  system clock (50 MHz), same clock as the AD sample stream.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle arm pulse; accepted only in IDLE or DONE.
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- trig_mode  in  1  0 = immediate trigger, 1 = rising threshold crossing.
- trig_level  in  DATA_W  threshold for trig_mode=1.
- decim  in  8  keep one sample every decim+1 clocks (0 = every clock).
- len  in  ADDR_W  capture length minus one (len+1 samples).
- tmo  in  TMO_W  auto-trigger after tmo decimated ticks in ARMED; 0 disables.
- sample_in  in  DATA_W  new sample every clk.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE; cleared by start, abort or rst.
- timed_out  out  1  last capture was forced by timeout; cleared on start.

Behaviour:
- Reset: state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, timed_out=0; all counters and prev-sample register cleared.
- start, decim, len, trig_mode, trig_level and tmo are latched on the accepting start cycle. Later input changes do not affect the running capture.
- start is ignored in ARMED/CAPTURE. abort beats start when both are asserted in the same cycle.
- Decimation: dcnt clears to 0 on accepted start and counts 0..decim_l. tick = (dcnt == decim_l). On tick, dcnt returns to 0.
- The tick condition is evaluated from the cycle after start. With decim_l=0, the first tick is the cycle after start.
- States:
  - IDLE: wait for start, then go to ARMED.
  - ARMED: on each tick, evaluate the trigger.
    - Mode 0: trigger on the first tick.
    - Mode 1: trigger when prev_valid && prev < trig_level && sample_in >= trig_level. prev is the sample at the previous tick; prev_valid is set after the first tick in ARMED. The first tick never triggers.
    - Timeout: tcnt counts ticks in ARMED. If tmo_l != 0 and tcnt reaches tmo_l-1 on a tick with no trigger, force a trigger on that tick and set timed_out.
    - On trigger, the trigger sample is written at address 0. Go to CAPTURE if len_l > 0, else go to DONE.
  - CAPTURE: each tick writes sample_in at the next address. When the sample at address len_l is written, go to DONE.
  - DONE: done=1; start re-arms (done clears, go to ARMED).
- Write timing: the registered write is issued the cycle after the tick. wr_en=1 for exactly one clk, with wr_data = sample_in of the tick cycle and wr_addr = sample index.
- The final write (addr len_l) appears in the same cycle that done rises.
- wr_addr holds its last value when wr_en=0.
- No wrap-around: at most len_l+1 writes per capture, addresses 0..len_l ascending.
- abort in ARMED/CAPTURE: go to IDLE next cycle and suppress any pending write. done stays 0; timed_out keeps its value.
- busy rises the cycle after the accepted start and falls with the final write or with abort.

Test Plan:
- Immediate, no decimation: decim=0, len=3, mode 0, ramp sample_in=0,1,2,... → 4 wr_en pulses on consecutive cycles, addr 0..3, consecutive ramp values; done high with the addr-3 write.
- Decimation: decim=2, len=1, mode 0 → wr_en pulses 3 clks apart, data values differ by 3; exactly 2 writes.
- Threshold: mode 1, level=1000, stream 900,950,999,1000,1200 with decim=0 → first write is 1000 at addr 0. A stream starting at 1500 does not trigger until it falls below 1000 and re-crosses upward.
- Timeout: mode 1, level=0xFFFF, tmo=5, decim=0 → forced trigger on the 5th tick; timed_out=1; len+1 writes; the next start clears timed_out.
- Abort/start conflicts:
  - abort mid-CAPTURE at addr 2 of len=7 → no further writes; IDLE; done=0.
  - start asserted during CAPTURE → ignored.
  - start+abort in the same cycle → IDLE.
- Reset mid-capture: rst=1 for one cycle during CAPTURE → all outputs return to reset values the next cycle; no wr_en afterwards until a new start.
